// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch mode sequencer: FSM states, statue codes, edit-field codes.
// Pure declarations; no latency or flow control of its own.
package stopwatch_pkg;

   typedef enum logic [3:0] {
      SW_IDLE     = 4'd0,
      SW_RUN      = 4'd1,
      SW_PAUSE    = 4'd2,
      CD_IDLE     = 4'd3,
      CD_EDIT_MIN = 4'd4,
      CD_EDIT_SEC = 4'd5,
      CD_RUN      = 4'd6,
      CD_PAUSE    = 4'd7,
      CD_ALARM    = 4'd8
   } state_t;

   localparam logic [1:0] STATUE_RUN   = 2'd0;
   localparam logic [1:0] STATUE_PAUSE = 2'd1;
   localparam logic [1:0] STATUE_CD    = 2'd2;

   localparam logic [1:0] EDIT_NONE = 2'd0;
   localparam logic [1:0] EDIT_MIN  = 2'd1;
   localparam logic [1:0] EDIT_SEC  = 2'd2;

   localparam logic [5:0] SEC_MAX = 6'd59;

   // Only the two running states let the datapath count; everything else holds/reloads.
   function automatic logic [1:0] statue_of(state_t s);
      if (s == SW_RUN) return STATUE_RUN;
      if (s == CD_RUN) return STATUE_CD;
      return STATUE_PAUSE;
   endfunction

   function automatic logic [1:0] edit_of(state_t s);
      if (s == CD_EDIT_MIN) return EDIT_MIN;
      if (s == CD_EDIT_SEC) return EDIT_SEC;
      return EDIT_NONE;
   endfunction

endpackage

// File: rtl/sw_alarm_timer.sv
// Alarm hold-time down-counter: start loads ALARM_CYCLES-1, expired rises once it reaches zero.
// Latency: expired is combinational from the count; no backpressure, clear wins over start.
module sw_alarm_timer #(
   parameter int ALARM_CYCLES = 300_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic clear,
   output logic expired
);

   localparam int W = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;

   logic [W-1:0] count_q;
   logic         run_q;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count_q <= '0;
         run_q   <= 1'b0;
      end else if (start) begin
         count_q <= W'(ALARM_CYCLES - 1);
         run_q   <= 1'b1;
      end else if (run_q && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign expired = run_q && (count_q == '0);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch/countdown mode sequencer and preset owner; all outputs registered, 1-cycle button latency.
// Optional ALARM_TIMEOUT_EN builds sw_alarm_timer so the alarm self-clears; buttons are pulses, no backpressure.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int ALARM_CYCLES = 300_000_000,
   parameter int MIN_MAX      = 59
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_start,
   input  logic       btn_set,
   input  logic       btn_inc,
   input  logic       countdown_done,
   input  logic [6:0] cur_centi,
   input  logic [5:0] cur_sec,
   input  logic [5:0] cur_min,
   output logic [1:0] statue,
   output logic [6:0] preset_centi,
   output logic [5:0] preset_sec,
   output logic [5:0] preset_min,
   output logic [1:0] edit_field,
   output logic       alarm
);

   localparam logic [5:0] MIN_LIMIT = 6'(MIN_MAX);

   if (ALARM_CYCLES < 1 || MIN_MAX < 0 || MIN_MAX > 63) begin : g_bad_params
      $error("stopwatch_ctrl: ALARM_CYCLES must be >= 1 and MIN_MAX must fit in 6 bits");
   end

   state_t     state_q, state_d;
   logic [1:0] statue_q, edit_field_q;
   logic       alarm_q;
   logic [6:0] centi_q, centi_d;
   logic [5:0] sec_q, sec_d;
   logic [5:0] min_q, min_d;

   logic mode_p, set_p, start_p, inc_p, any_p;
   logic preset_nz;
   logic alarm_expired;

   // Strict priority: only the highest pending button of a cycle is seen by the FSM.
   assign mode_p    = btn_mode;
   assign set_p     = btn_set & ~btn_mode;
   assign start_p   = btn_start & ~btn_mode & ~btn_set;
   assign inc_p     = btn_inc & ~btn_mode & ~btn_set & ~btn_start;
   assign any_p     = btn_mode | btn_set | btn_start | btn_inc;
   assign preset_nz = (centi_q != '0) || (sec_q != '0) || (min_q != '0);

`ifdef ALARM_TIMEOUT_EN
   sw_alarm_timer #(
      .ALARM_CYCLES(ALARM_CYCLES)
   ) u_alarm_timer (
      .clk     (clk),
      .rst     (rst),
      .start   ((state_q == CD_RUN) && (state_d == CD_ALARM)),
      .clear   ((state_q == CD_ALARM) && (state_d != CD_ALARM)),
      .expired (alarm_expired)
   );
`else
   assign alarm_expired = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      centi_d = centi_q;
      sec_d   = sec_q;
      min_d   = min_q;
      case (state_q)
         SW_IDLE, SW_PAUSE: begin
            if (mode_p)       state_d = CD_IDLE;
            else if (start_p) state_d = SW_RUN;
         end
         SW_RUN: begin
            if (start_p) state_d = SW_PAUSE;
         end
         CD_IDLE: begin
            if (mode_p)                      state_d = SW_IDLE;
            else if (set_p)                  state_d = CD_EDIT_MIN;
            else if (start_p && preset_nz)   state_d = CD_RUN;
         end
         CD_EDIT_MIN: begin
            if (set_p) begin
               state_d = CD_EDIT_SEC;
            end else if (inc_p) begin
               min_d   = (min_q >= MIN_LIMIT) ? 6'd0 : min_q + 6'd1;
               centi_d = '0;
            end
         end
         CD_EDIT_SEC: begin
            if (set_p) begin
               state_d = CD_IDLE;
            end else if (inc_p) begin
               sec_d   = (sec_q >= SEC_MAX) ? 6'd0 : sec_q + 6'd1;
               centi_d = '0;
            end
         end
         CD_RUN: begin
            // Reaching zero outranks a coincident start so the alarm is never missed.
            if (countdown_done) begin
               state_d = CD_ALARM;
            end else if (start_p) begin
               state_d = CD_PAUSE;
               centi_d = cur_centi;
               sec_d   = cur_sec;
               min_d   = cur_min;
            end
         end
         CD_PAUSE: begin
            if (set_p)        state_d = CD_IDLE;
            else if (start_p) state_d = CD_RUN;
         end
         CD_ALARM: begin
            if (any_p) begin
               state_d = CD_IDLE;
               centi_d = '0;
               sec_d   = '0;
               min_d   = '0;
            end else if (alarm_expired) begin
               state_d = CD_IDLE;
            end
         end
         default: state_d = SW_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= SW_IDLE;
         statue_q     <= STATUE_PAUSE;
         edit_field_q <= EDIT_NONE;
         alarm_q      <= 1'b0;
         centi_q      <= '0;
         sec_q        <= '0;
         min_q        <= '0;
      end else begin
         state_q      <= state_d;
         statue_q     <= statue_of(state_d);
         edit_field_q <= edit_of(state_d);
         alarm_q      <= (state_d == CD_ALARM);
         centi_q      <= centi_d;
         sec_q        <= sec_d;
         min_q        <= min_d;
      end
   end

   assign statue       = statue_q;
   assign edit_field   = edit_field_q;
   assign alarm        = alarm_q;
   assign preset_centi = centi_q;
   assign preset_sec   = sec_q;
   assign preset_min   = min_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with ALARM_CYCLES=10; inputs change on negedge, outputs checked on negedge.
module tb_stopwatch_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_mode = 1'b0, btn_start = 1'b0, btn_set = 1'b0, btn_inc = 1'b0;
   logic       countdown_done = 1'b0;
   logic [6:0] cur_centi = '0;
   logic [5:0] cur_sec = '0, cur_min = '0;
   logic [1:0] statue, edit_field;
   logic [6:0] preset_centi;
   logic [5:0] preset_sec, preset_min;
   logic       alarm;

   int n_cmp = 0;
   int n_bad = 0;

   stopwatch_ctrl #(
      .ALARM_CYCLES(10),
      .MIN_MAX     (59)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .btn_mode       (btn_mode),
      .btn_start      (btn_start),
      .btn_set        (btn_set),
      .btn_inc        (btn_inc),
      .countdown_done (countdown_done),
      .cur_centi      (cur_centi),
      .cur_sec        (cur_sec),
      .cur_min        (cur_min),
      .statue         (statue),
      .preset_centi   (preset_centi),
      .preset_sec     (preset_sec),
      .preset_min     (preset_min),
      .edit_field     (edit_field),
      .alarm          (alarm)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One-cycle pulse; returns on the negedge after the edge that consumed it.
   task automatic pulse(input logic m, input logic s, input logic st, input logic i);
      @(negedge clk);
      btn_mode = m; btn_set = s; btn_start = st; btn_inc = i;
      @(negedge clk);
      btn_mode = 1'b0; btn_set = 1'b0; btn_start = 1'b0; btn_inc = 1'b0;
   endtask

   task automatic done_pulse();
      @(negedge clk);
      countdown_done = 1'b1;
      @(negedge clk);
      countdown_done = 1'b0;
   endtask

   initial begin
      int acnt;

      // Reset state
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_statue", statue, 1);
      check("rst_centi", preset_centi, 0);
      check("rst_sec", preset_sec, 0);
      check("rst_min", preset_min, 0);
      check("rst_edit", edit_field, 0);
      check("rst_alarm", alarm, 0);

      // Stopwatch start / pause
      pulse(0, 0, 1, 0);
      check("sw_run_statue", statue, 0);
      pulse(0, 0, 1, 0);
      check("sw_pause_statue", statue, 1);
      check("sw_alarm", alarm, 0);

      // Preset edit to 03:02.00
      pulse(1, 0, 0, 0);
      check("cd_idle_statue", statue, 1);
      check("cd_idle_edit", edit_field, 0);
      pulse(0, 1, 0, 0);
      check("edit_min_field", edit_field, 1);
      repeat (3) pulse(0, 0, 0, 1);
      check("edit_min_val", preset_min, 3);
      pulse(0, 1, 0, 0);
      check("edit_sec_field", edit_field, 2);
      repeat (2) pulse(0, 0, 0, 1);
      check("edit_sec_val", preset_sec, 2);
      pulse(0, 1, 0, 0);
      check("edit_done_field", edit_field, 0);
      check("p302_min", preset_min, 3);
      check("p302_sec", preset_sec, 2);
      check("p302_centi", preset_centi, 0);
      check("p302_statue", statue, 1);

      // Wrap both fields on the way to 00:01.00
      pulse(0, 1, 0, 0);
      repeat (56) pulse(0, 0, 0, 1);
      check("min_at_max", preset_min, 59);
      pulse(0, 0, 0, 1);
      check("min_wrap", preset_min, 0);
      pulse(0, 1, 0, 0);
      repeat (57) pulse(0, 0, 0, 1);
      check("sec_at_max", preset_sec, 59);
      pulse(0, 0, 0, 1);
      check("sec_wrap", preset_sec, 0);
      pulse(0, 0, 0, 1);
      pulse(0, 1, 0, 0);
      check("p001_sec", preset_sec, 1);
      check("p001_edit", edit_field, 0);

      // Countdown run, pause capture at 00:00.37, resume, alarm, button exit
      cur_min = 6'd0; cur_sec = 6'd1; cur_centi = 7'd0;
      pulse(0, 0, 1, 0);
      check("cd_run_statue", statue, 2);
      cur_sec = 6'd0; cur_centi = 7'd37;
      pulse(0, 0, 1, 0);
      check("cd_pause_statue", statue, 1);
      check("cd_pause_centi", preset_centi, 37);
      check("cd_pause_sec", preset_sec, 0);
      check("cd_pause_min", preset_min, 0);
      pulse(0, 0, 1, 0);
      check("cd_resume_statue", statue, 2);
      check("cd_resume_centi", preset_centi, 37);
      cur_centi = 7'd0;
      done_pulse();
      check("alarm_on", alarm, 1);
      check("alarm_statue", statue, 1);
      pulse(0, 0, 1, 0);
      check("alarm_off", alarm, 0);
      check("alarm_clr_centi", preset_centi, 0);
      check("alarm_clr_min", preset_min, 0);
      check("alarm_exit_edit", edit_field, 0);

      // Zero preset blocks start; done ignored outside CD_RUN
      pulse(0, 0, 1, 0);
      check("zero_start_blocked", statue, 1);
      done_pulse();
      check("done_ignored", alarm, 0);

      // CD_PAUSE -> set keeps remaining time as preset
      pulse(0, 1, 0, 0);
      pulse(0, 0, 0, 1);
      pulse(0, 1, 0, 0);
      pulse(0, 1, 0, 0);
      pulse(0, 0, 1, 0);
      check("run2_statue", statue, 2);
      cur_min = 6'd0; cur_sec = 6'd45; cur_centi = 7'd12;
      pulse(0, 0, 1, 0);
      pulse(0, 1, 0, 0);
      check("pause_set_statue", statue, 1);
      check("pause_set_edit", edit_field, 0);
      check("pause_set_sec", preset_sec, 45);
      check("pause_set_centi", preset_centi, 12);
      pulse(0, 0, 1, 0);
      check("run3_statue", statue, 2);

      // Reset mid-run
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_statue", statue, 1);
      check("midrst_sec", preset_sec, 0);
      check("midrst_centi", preset_centi, 0);

      // Simultaneous pulses: mode beats start, set beats inc
      pulse(1, 0, 1, 0);
      check("mode_start_statue", statue, 1);
      pulse(0, 1, 0, 0);
      check("mode_start_in_cd", edit_field, 1);
      pulse(0, 1, 0, 1);
      check("set_inc_field", edit_field, 2);
      check("set_inc_min", preset_min, 0);
      pulse(0, 1, 0, 0);

      // Mode ignored while stopwatch runs
      pulse(1, 0, 0, 0);
      pulse(0, 0, 1, 0);
      check("sw_run2_statue", statue, 0);
      pulse(1, 0, 0, 0);
      check("mode_ignored_run", statue, 0);
      pulse(0, 0, 1, 0);
      check("sw_pause2_statue", statue, 1);

      // Alarm hold time
      pulse(1, 0, 0, 0);
      pulse(0, 1, 0, 0);
      pulse(0, 0, 0, 1);
      pulse(0, 1, 0, 0);
      pulse(0, 1, 0, 0);
      cur_min = 6'd1; cur_sec = 6'd0; cur_centi = 7'd0;
      pulse(0, 0, 1, 0);
      check("run4_statue", statue, 2);
      done_pulse();
      acnt = 0;
      for (int k = 0; k < 40; k++) begin
         if (alarm) acnt++;
         @(negedge clk);
      end
`ifdef ALARM_TIMEOUT_EN
      check("alarm_hold_cycles", acnt, 10);
      check("timeout_alarm", alarm, 0);
      check("timeout_statue", statue, 1);
      check("timeout_edit", edit_field, 0);
`else
      check("alarm_hold_cycles", acnt, 40);
      pulse(0, 0, 0, 1);
      check("inc_exit_alarm", alarm, 0);
      check("inc_exit_min", preset_min, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
